bounce_rr_arbiter: RTL and testbench

- Arbitrates one shared resource among N requesters using a bouncing one-hot priority pointer. The pointer sweeps from bit 0 up to bit N-1, reverses, sweeps back down, and repeats.
- Sits in front of any shared datapath resource. Sequences access grant by grant, with hold-until-release semantics and a watchdog timeout.

---
 rtl/bounce_arb_pkg.sv | 43 ++++
 rtl/bounce_rr_arbiter_search.sv | 39 +++
 rtl/bounce_rr_arbiter.sv | 116 +++++++++++
 tb/tb_bounce_rr_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bounce_arb_pkg.sv
// Shared types and helpers for bouncing-pointer arbitration blocks.
// The pointer sweeps 0..N-1, reverses, sweeps back to 0, and repeats.
package bounce_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

   localparam int PW = 16;

   typedef struct packed {
      logic [PW-1:0] pos;
      logic          dir;
   } bpos_t;

   // One bounce step; reverses at either end of the 0..n-1 range.
   function automatic bpos_t bounce_next(bpos_t c, int unsigned n);
      bpos_t r;
      if (c.dir == DIR_UP) begin
         if (c.pos == PW'(n - 1)) begin
            r.pos = PW'(n - 2);
            r.dir = DIR_DN;
         end else begin
            r.pos = c.pos + PW'(1);
            r.dir = DIR_UP;
         end
      end else begin
         if (c.pos == '0) begin
            r.pos = PW'(1);
            r.dir = DIR_UP;
         end else begin
            r.pos = c.pos - PW'(1);
            r.dir = DIR_DN;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bounce_rr_arbiter_search.sv
// Combinational winner search over 2N-2 positions in bounce order.
// Reports the first requesting index and the direction it was visited in.
module bounce_search
   import bounce_arb_pkg::*;
#(
   parameter  int N  = 8,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [N-1:0]  ptr_i,
   input  logic          dir_i,
   output logic          hit_o,
   output logic [IW-1:0] wp_o,
   output logic          wd_o
);

   bpos_t cur;

   // Walk from (ptr,dir) and latch the first requester seen.
   always_comb begin
      cur   = '0;
      hit_o = 1'b0;
      wp_o  = '0;
      wd_o  = DIR_UP;
      for (int i = 0; i < N; i++) begin
         if (ptr_i[i]) cur.pos = PW'(i);
      end
      cur.dir = dir_i;
      for (int s = 0; s < 2*N-2; s++) begin
         if (!hit_o && req_i[cur.pos[IW-1:0]]) begin
            hit_o = 1'b1;
            wp_o  = cur.pos[IW-1:0];
            wd_o  = cur.dir;
         end
         cur = bounce_next(cur, N);
      end
   end

endmodule

// File: rtl/bounce_rr_arbiter.sv
// Bouncing-priority arbiter: grant held until done, request drop or
// watchdog expiry; one idle bubble between consecutive grants.
module bounce_rr_arbiter
   import bounce_arb_pkg::*;
#(
   parameter int N       = 8,
   parameter int TIMEOUT = 255,
   parameter int TW      = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic         done,
   output logic [N-1:0] grant,
   output logic         grant_valid,
   output logic [N-1:0] ptr,
   output logic         dir,
   output logic         timeout
);

   localparam int IW = $clog2(N);
   localparam logic WD_EN = (TIMEOUT != 0);
   localparam logic [TW-1:0] HOLD_LAST =
      (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] HOLD_MAX = '1;

   state_e        state_q;
   logic [N-1:0]  grant_q;
   logic [N-1:0]  ptr_q;
   logic          dir_q;
   logic          timeout_q;
   logic [TW-1:0] hold_q;
   logic [IW-1:0] wp_q;
   logic          wd_q;

   logic          hit;
   logic [IW-1:0] wp;
   logic          wd;

   logic          rel_done;
   logic          rel_drop;
   logic          rel_wdog;
   logic          release_d;
   bpos_t         win_d;
   bpos_t         nxt_d;
   logic [N-1:0]  ptr_d;

   bounce_search #(.N(N)) u_search (
      .req_i (req),
      .ptr_i (ptr_q),
      .dir_i (dir_q),
      .hit_o (hit),
      .wp_o  (wp),
      .wd_o  (wd)
   );

   // Release causes and the pointer position one step past the holder.
   always_comb begin
      rel_done  = done;
      rel_drop  = !req[wp_q];
      rel_wdog  = WD_EN && (hold_q == HOLD_LAST);
      release_d = rel_done | rel_drop | rel_wdog;
      win_d.pos = PW'(wp_q);
      win_d.dir = wd_q;
      nxt_d     = bounce_next(win_d, N);
      ptr_d     = '0;
      for (int i = 0; i < N; i++) begin
         ptr_d[i] = (nxt_d.pos == PW'(i));
      end
   end

   // Grant FSM with hold counter and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         ptr_q     <= N'(1);
         dir_q     <= DIR_UP;
         timeout_q <= 1'b0;
         hold_q    <= '0;
         wp_q      <= '0;
         wd_q      <= DIR_UP;
      end else begin
         timeout_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (hit) begin
                  grant_q <= N'(1) << wp;
                  wp_q    <= wp;
                  wd_q    <= wd;
                  hold_q  <= '0;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (release_d) begin
                  grant_q   <= '0;
                  ptr_q     <= ptr_d;
                  dir_q     <= nxt_d.dir;
                  timeout_q <= rel_wdog && !rel_done && !rel_drop;
                  state_q   <= IDLE;
               end else if (hold_q != HOLD_MAX) begin
                  hold_q <= hold_q + TW'(1);
               end
            end
         endcase
      end
   end

   assign grant       = grant_q;
   assign grant_valid = |grant_q;
   assign ptr         = ptr_q;
   assign dir         = dir_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_bounce_rr_arbiter.sv
// Scenario bench for bounce_rr_arbiter (N=8, TIMEOUT=4).
// Expected grant indices are queued at stimulus time and popped on grant.
module tb_bounce_rr_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] req = '0;
   logic       done = 1'b0;
   logic [7:0] grant;
   logic       grant_valid;
   logic [7:0] ptr;
   logic       dir;
   logic       timeout;

   int checks = 0;
   int fails  = 0;
   int exp_q[$];

   bounce_rr_arbiter #(.N(8), .TIMEOUT(4), .TW(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_valid (grant_valid),
      .ptr         (ptr),
      .dir         (dir),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      done  = 1'b0;
      exp_q.delete();
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Wait for a grant and compare against the scoreboard head.
   task automatic expect_grant(input string name, output int cyc);
      int e;
      logic [7:0] eg;
      cyc = 0;
      while (!grant_valid && cyc < 20) begin
         tick();
         cyc++;
      end
      checks++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL %s: grant=%b seen, scoreboard empty", name, grant);
      end else begin
         e  = exp_q.pop_front();
         eg = 8'd1 << e;
         if (grant !== eg || grant_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s: grant=%b gv=%b, expected %b gv=1",
                     name, grant, grant_valid, eg);
         end
      end
   endtask

   // Pulse done for one cycle and check the release.
   task automatic release_done(input string name);
      done = 1'b1;
      tick();
      done = 1'b0;
      checks++;
      if (grant !== 8'h00 || grant_valid !== 1'b0 || timeout !== 1'b0) begin
         fails++;
         $display("FAIL %s_release: grant=%b gv=%b to=%b, expected 0/0/0",
                  name, grant, grant_valid, timeout);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req   = '0;
      done  = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (i == 2) reset = 1'b0;
         tick();
         checks++;
         if (ptr !== 8'h01 || dir !== 1'b0 ||
             grant !== 8'h00 || grant_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle cyc%0d: ptr=%b dir=%b grant=%b gv=%b, expected 00000001/0/0/0",
                     i, ptr, dir, grant, grant_valid);
         end
      end
   endtask

   task automatic test_all_requesting();
      int seq[17] = '{0,1,2,3,4,5,6,7,6,5,4,3,2,1,0,1,2};
      int cyc;
      logic [7:0] ep;
      logic ed;
      do_reset();
      req = 8'hFF;
      for (int k = 0; k < 16; k++) begin
         exp_q.push_back(seq[k]);
         expect_grant($sformatf("order%0d", k), cyc);
         checks++;
         if (cyc !== 1) begin
            fails++;
            $display("FAIL bubble%0d: grant after %0d cycles, expected 1",
                     k, cyc);
         end
         release_done($sformatf("order%0d", k));
         ep = 8'd1 << seq[k+1];
         ed = (seq[k+1] < seq[k]);
         checks++;
         if (ptr !== ep || dir !== ed) begin
            fails++;
            $display("FAIL ptr_after%0d: ptr=%b dir=%b, expected %b dir=%b",
                     k, ptr, dir, ep, ed);
         end
      end
      req = '0;
   endtask

   task automatic test_sparse();
      int cyc;
      do_reset();
      req = 8'hFF;
      for (int k = 0; k < 5; k++) begin
         exp_q.push_back(k);
         expect_grant($sformatf("sparse_pre%0d", k), cyc);
         release_done("sparse_pre");
      end
      req = 8'b0000_0100;
      checks++;
      if (ptr !== 8'b0010_0000 || dir !== 1'b0) begin
         fails++;
         $display("FAIL sparse_start: ptr=%b dir=%b, expected 00100000 dir=0",
                  ptr, dir);
      end
      exp_q.push_back(2);
      expect_grant("sparse_grant", cyc);
      release_done("sparse");
      checks++;
      if (ptr !== 8'b0000_0010 || dir !== 1'b1) begin
         fails++;
         $display("FAIL sparse_ptr: ptr=%b dir=%b, expected 00000010 dir=1",
                  ptr, dir);
      end
      req = '0;
   endtask

   task automatic test_watchdog();
      int cyc;
      do_reset();
      req = 8'b0000_1000;
      exp_q.push_back(3);
      expect_grant("wdog_grant", cyc);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (grant !== 8'b0000_1000 || timeout !== 1'b0) begin
            fails++;
            $display("FAIL wdog_hold%0d: grant=%b to=%b, expected 00001000 to=0",
                     i, grant, timeout);
         end
      end
      tick();
      checks++;
      if (grant !== 8'h00 || timeout !== 1'b1) begin
         fails++;
         $display("FAIL wdog_fire: grant=%b to=%b, expected 0 to=1",
                  grant, timeout);
      end
      checks++;
      if (ptr !== 8'b0001_0000 || dir !== 1'b0) begin
         fails++;
         $display("FAIL wdog_ptr: ptr=%b dir=%b, expected 00010000 dir=0",
                  ptr, dir);
      end
      exp_q.push_back(3);
      expect_grant("wdog_regrant", cyc);
      checks++;
      if (timeout !== 1'b0) begin
         fails++;
         $display("FAIL wdog_pulse_width: to=%b, expected 0", timeout);
      end
      tick();
      tick();
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      checks++;
      if (grant !== 8'h00 || timeout !== 1'b0) begin
         fails++;
         $display("FAIL wdog_with_done: grant=%b to=%b, expected 0 to=0",
                  grant, timeout);
      end
      req = '0;
   endtask

   task automatic test_req_drop();
      int cyc;
      do_reset();
      req = 8'b0000_0100;
      exp_q.push_back(2);
      expect_grant("drop_grant", cyc);
      tick();
      req = '0;
      tick();
      checks++;
      if (grant !== 8'h00 || timeout !== 1'b0) begin
         fails++;
         $display("FAIL drop_release: grant=%b to=%b, expected 0 to=0",
                  grant, timeout);
      end
      req = 8'b0000_0100;
      exp_q.push_back(2);
      expect_grant("drop_regrant", cyc);
      done = 1'b1;
      req  = '0;
      tick();
      done = 1'b0;
      checks++;
      if (grant !== 8'h00 || timeout !== 1'b0) begin
         fails++;
         $display("FAIL drop_done_release: grant=%b to=%b, expected 0 to=0",
                  grant, timeout);
      end
      tick();
      checks++;
      if (grant !== 8'h00 || ptr !== 8'b0000_0010 || dir !== 1'b1) begin
         fails++;
         $display("FAIL drop_single: grant=%b ptr=%b dir=%b, expected 0 00000010 dir=1",
                  grant, ptr, dir);
      end
   endtask

   task automatic test_reset_mid_grant();
      int cyc;
      do_reset();
      req = 8'hFF;
      for (int k = 0; k < 6; k++) begin
         exp_q.push_back(k);
         expect_grant($sformatf("mid_pre%0d", k), cyc);
         release_done("mid_pre");
      end
      exp_q.push_back(6);
      expect_grant("mid_grant6", cyc);
      checks++;
      if (dir !== 1'b0) begin
         fails++;
         $display("FAIL mid_dir: dir=%b, expected 0", dir);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (grant !== 8'h00 || grant_valid !== 1'b0 ||
          ptr !== 8'h01 || dir !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset: grant=%b gv=%b ptr=%b dir=%b, expected 0/0/00000001/0",
                  grant, grant_valid, ptr, dir);
      end
      exp_q.push_back(0);
      expect_grant("mid_after_reset", cyc);
      req = '0;
   endtask

   initial begin
      test_reset();
      test_all_requesting();
      test_sparse();
      test_watchdog();
      test_req_drop();
      test_reset_mid_grant();
      checks++;
      if (exp_q.size() !== 0) begin
         fails++;
         $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
